// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches one word per instruction over req/ack,
// strobes the IR, then waits for the control unit to retire the instruction.
module instr_fetch #(
   parameter int              ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       code,
   output logic              iir,
   input  logic              exec_done,
   input  logic              jmp_take,
   input  logic [ADDR_W-1:0] jmp_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic [15:0]       icount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      LOAD = 2'd2,
      EXEC = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [15:0]       IC_ONE = 16'd1;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] pc_q;
   logic [15:0]       code_q;
   logic [15:0]       icount_q;

   logic fetch_hit;
   logic retire;

   assign fetch_hit = (state == REQ) && mem_ack;
   assign retire    = (state == EXEC) && exec_done;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state selection
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (run)       state_nx = REQ;
         REQ:  if (mem_ack)   state_nx = LOAD;
         LOAD:                state_nx = EXEC;
         EXEC: if (exec_done) state_nx = run ? REQ : IDLE;
         default:             state_nx = IDLE;
      endcase
   end

   // Moore outputs decoded from state only
   always_comb begin
      mem_req = 1'b0;
      iir     = 1'b0;
      busy    = 1'b1;
      unique case (state)
         IDLE:    busy    = 1'b0;
         REQ:     mem_req = 1'b1;
         LOAD:    iir     = 1'b1;
         EXEC:    ;
         default: busy    = 1'b0;
      endcase
   end

   // Instruction word captured on the accepted ack, held until the next one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         code_q <= 16'h0000;
      else if (fetch_hit) code_q <= mem_rdata;
   end

   // PC advances (sequential or jump) when the instruction retires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pc_q <= RESET_PC;
      else if (retire) pc_q <= jmp_take ? jmp_addr : pc_q + PC_ONE;
   end

   // Retired-instruction counter, free-running wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      icount_q <= 16'h0000;
      else if (retire) icount_q <= icount_q + IC_ONE;
   end

   assign mem_addr = pc_q;
   assign pc       = pc_q;
   assign code     = code_q;
   assign icount   = icount_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run, checked
// against an instruction-level model of PC, fetched word and retire count.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] code;
   logic        iir;
   logic        exec_done;
   logic        jmp_take;
   logic [15:0] jmp_addr;
   logic [15:0] pc;
   logic        busy;
   logic [15:0] icount;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_pc;
   logic [15:0] exp_ic;
   logic [15:0] mem [logic [15:0]];

   instr_fetch #(
      .ADDR_W  (16),
      .RESET_PC(16'h0000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .code     (code),
      .iir      (iir),
      .exec_done(exec_done),
      .jmp_take (jmp_take),
      .jmp_addr (jmp_addr),
      .pc       (pc),
      .busy     (busy),
      .icount   (icount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] word(input logic [15:0] a);
      if (!mem.exists(a)) mem[a] = 16'($urandom);
      return mem[a];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full instruction: optional wait states, LOAD strobe, EXEC with
   // optional stray inputs, then retire and compare against the model.
   task automatic do_instr(input int wt, input int dly, input bit jmp,
                           input logic [15:0] tgt, input bit stray,
                           input bit drop_run, input bit frc);
      int n;
      logic [15:0] w;
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", 32'(mem_req), 32'd1);
      chk("mem_addr", 32'(mem_addr), 32'(exp_pc));
      for (int i = 0; i < wt; i++) begin
         chk("wait_iir", 32'(iir), 32'd0);
         @(negedge clk);
         chk("wait_req", 32'(mem_req), 32'd1);
         chk("wait_addr", 32'(mem_addr), 32'(exp_pc));
      end
      w = word(exp_pc);
      mem_ack = 1'b1;
      mem_rdata = w;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      chk("iir_pulse", 32'(iir), 32'd1);
      chk("code_load", 32'(code), 32'(w));
      chk("req_drop", 32'(mem_req), 32'd0);
      @(negedge clk);
      chk("iir_end", 32'(iir), 32'd0);
      chk("busy_exec", 32'(busy), 32'd1);
      for (int i = 0; i < dly; i++) begin
         if (stray) begin
            mem_ack = 1'b1;
            jmp_take = 1'b1;
            jmp_addr = 16'($urandom);
         end
         @(negedge clk);
         mem_ack = 1'b0;
         jmp_take = 1'b0;
         chk("exec_code", 32'(code), 32'(w));
         chk("exec_pc", 32'(pc), 32'(exp_pc));
         chk("exec_req", 32'(mem_req), 32'd0);
      end
      if (drop_run) run = 1'b0;
      if (frc) begin
         force dut.icount_q = 16'hFFFF;
         #1;
         release dut.icount_q;
         exp_ic = 16'hFFFF;
      end
      exec_done = 1'b1;
      jmp_take = jmp;
      jmp_addr = tgt;
      @(negedge clk);
      exec_done = 1'b0;
      jmp_take = 1'b0;
      exp_pc = jmp ? tgt : exp_pc + 16'd1;
      exp_ic = exp_ic + 16'd1;
      chk("retire_pc", 32'(pc), 32'(exp_pc));
      chk("icount", 32'(icount), 32'(exp_ic));
      if (drop_run) begin
         chk("park_busy", 32'(busy), 32'd0);
         chk("park_req", 32'(mem_req), 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      run = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = 16'h0000;
      exec_done = 1'b0;
      jmp_take = 1'b0;
      jmp_addr = 16'h0000;
      mem[16'h0000] = 16'h0805;
      mem[16'h0001] = 16'h3012;
      exp_pc = 16'h0000;
      exp_ic = 16'h0000;
      #1 rst_n = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_iir", 32'(iir), 32'd0);
      chk("rst_code", 32'(code), 32'd0);
      chk("rst_icount", 32'(icount), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      rst_n = 1'b1;
      run = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("start_req", 32'(mem_req), 32'd1);
      chk("start_addr", 32'(mem_addr), 32'd0);

      do_instr(0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      do_instr(0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("seq_pc2", 32'(pc), 32'd2);
      chk("seq_ic2", 32'(icount), 32'd2);

      do_instr(4, 1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      do_instr(0, 2, 1'b1, 16'h0040, 1'b1, 1'b0, 1'b0);
      chk("jmp_addr", 32'(mem_addr), 32'h0040);

      do_instr(1, 0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      do_instr(0, 1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("wrap_pc", 32'(pc), 32'd0);
      chk("wrap_ic", 32'(icount), 32'd0);

      do_instr(2, 1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      chk("idle_req", 32'(mem_req), 32'd0);
      chk("idle_pc", 32'(pc), 32'(exp_pc));
      run = 1'b1;

      for (int k = 0; k < 40; k++) begin
         do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), 16'($urandom),
                  1'($urandom), 1'b0, 1'b0);
      end

      @(negedge clk);
      chk("mid_req", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", 32'(mem_req), 32'd0);
      chk("arst_pc", 32'(pc), 32'd0);
      chk("arst_code", 32'(code), 32'd0);
      chk("arst_ic", 32'(icount), 32'd0);
      exp_pc = 16'h0000;
      exp_ic = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      run = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 16'hBEEF;
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      chk("stray_code", 32'(code), 32'd0);
      chk("stray_busy", 32'(busy), 32'd0);
      run = 1'b1;
      do_instr(0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("restart_pc", 32'(pc), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
